// File: rtl/channel_fifo_src_if.sv
// Producer/consumer bundle for channel_fifo_src.
// The master drives the requests and the slave (the FIFO) drives the flags and data.
interface channel_fifo_src_if #(
   parameter int unsigned WIDTH = 32,
   parameter int unsigned DEPTH = 4
);
   localparam int unsigned CW = $clog2(DEPTH + 1);

   logic [WIDTH-1:0] in_data;
   logic             write_valid;
   logic             write_ready;
   logic             read_valid;
   logic             read_ready;
   logic [WIDTH-1:0] out_data;
   logic [CW-1:0]    count;

   modport master (
      output in_data, write_valid, read_valid,
      input  write_ready, read_ready, out_data, count
   );

   modport slave (
      input  in_data, write_valid, read_valid,
      output write_ready, read_ready, out_data, count
   );
endinterface

// File: rtl/channel_fifo_src.sv
// Circular-buffer FIFO with a registered pop output and combinational flags decoded
// from the occupancy counter. The flags never depend on the opposite port's request.
module channel_fifo_src #(
   parameter int unsigned WIDTH = 32,
   parameter int unsigned DEPTH = 4
) (
   input logic               clk,
   input logic               rst,
   channel_fifo_src_if.slave bus
);
   localparam int unsigned PW = $clog2(DEPTH);
   localparam int unsigned CW = $clog2(DEPTH + 1);

   if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : gen_bad_depth
      $error("channel_fifo_src: DEPTH must be a power of two, at least 2");
   end

   logic [WIDTH-1:0] mem [DEPTH];
   logic [PW-1:0]    wp_q, wp_d;
   logic [PW-1:0]    rp_q, rp_d;
   logic [CW-1:0]    cnt_q, cnt_d;
   logic [WIDTH-1:0] out_q, out_d;
   logic             full, empty, push, pop;

   always_comb begin
      full  = (cnt_q == CW'(DEPTH));
      empty = (cnt_q == '0);
      // A request against a full/empty buffer is dropped even if the other side moves.
      push  = bus.write_valid && !full;
      pop   = bus.read_valid && !empty;

      wp_d  = wp_q;
      rp_d  = rp_q;
      cnt_d = cnt_q;
      out_d = out_q;

      if (push) wp_d = wp_q + PW'(1);
      if (pop) begin
         rp_d  = rp_q + PW'(1);
         out_d = mem[rp_q];
      end

      case ({push, pop})
         2'b10:   cnt_d = cnt_q + CW'(1);
         2'b01:   cnt_d = cnt_q - CW'(1);
         default: cnt_d = cnt_q;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         wp_q  <= '0;
         rp_q  <= '0;
         cnt_q <= '0;
         out_q <= '0;
      end else begin
         wp_q  <= wp_d;
         rp_q  <= rp_d;
         cnt_q <= cnt_d;
         out_q <= out_d;
      end
   end

   // Storage is intentionally not reset; an entry is only read after it was written.
   always_ff @(posedge clk) begin
      if (push && !rst) mem[wp_q] <= bus.in_data;
   end

   assign bus.write_ready = !full;
   assign bus.read_ready  = !empty;
   assign bus.count       = cnt_q;
   assign bus.out_data    = out_q;
endmodule

// File: tb/tb_channel_fifo_src.sv
// Directed bench for channel_fifo_src: a queue model checked every cycle plus
// hand-computed expectations for each scenario.
module tb_channel_fifo_src;
   localparam int unsigned WIDTH = 32;
   localparam int unsigned DEPTH = 4;

   logic clk = 1'b0;
   logic rst;
   int   n_checks = 0;
   int   n_pass = 0;

   channel_fifo_src_if #(.WIDTH(WIDTH), .DEPTH(DEPTH)) bus ();

   channel_fifo_src #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
   endtask

   // Reference model: a queue of stored words plus the last popped word.
   logic [WIDTH-1:0] m_q[$];
   logic [WIDTH-1:0] m_out;
   bit               m_valid = 0;

   initial begin
      forever begin
         @(negedge clk);
         if (m_valid) begin
            chk("model write_ready", 32'(bus.write_ready), 32'(m_q.size() != DEPTH));
            chk("model read_ready", 32'(bus.read_ready), 32'(m_q.size() != 0));
            chk("model count", 32'(bus.count), 32'(m_q.size()));
            chk("model out_data", bus.out_data, m_out);
         end
         // Inputs are stable here until the next rising edge: apply them to the model.
         if (rst === 1'b1) begin
            m_q.delete();
            m_out   = '0;
            m_valid = 1;
         end else if (m_valid) begin
            bit can_pop, can_push;
            can_pop  = bus.read_valid && m_q.size() != 0;
            can_push = bus.write_valid && m_q.size() != DEPTH;
            if (can_pop) m_out = m_q.pop_front();
            if (can_push) m_q.push_back(bus.in_data);
         end
      end
   end

   task automatic cyc(input logic wv, input logic [31:0] d, input logic rv);
      bus.write_valid = wv;
      bus.in_data     = d;
      bus.read_valid  = rv;
      @(posedge clk);
      #1;
   endtask

   initial begin
      int sum;
      rst = 1'b1;
      bus.write_valid = 1'b0;
      bus.read_valid  = 1'b0;
      bus.in_data     = '0;
      cyc(0, 0, 0);
      cyc(0, 0, 0);
      rst = 1'b0;

      // Reset then idle.
      for (int i = 0; i < 10; i++) begin
         cyc(0, 32'hDEAD_0000 + 32'(i), 0);
         chk("idle write_ready", 32'(bus.write_ready), 1);
         chk("idle read_ready", 32'(bus.read_ready), 0);
         chk("idle count", 32'(bus.count), 0);
         chk("idle out_data", bus.out_data, 0);
      end

      // Fill, overflow attempt, drain.
      cyc(1, 5, 0);
      chk("first push read_ready", 32'(bus.read_ready), 1);
      cyc(1, 6, 0);
      cyc(1, 7, 0);
      cyc(1, 8, 0);
      chk("full count", 32'(bus.count), 4);
      chk("full write_ready", 32'(bus.write_ready), 0);
      cyc(1, 9, 0);
      chk("overflow count", 32'(bus.count), 4);
      for (int i = 0; i < 4; i++) begin
         cyc(0, 0, 1);
         chk("drain out_data", bus.out_data, 32'(5 + i));
      end
      chk("drained read_ready", 32'(bus.read_ready), 0);

      // Consumer handshake: pulse read_valid, sample two cycles later.
      for (int i = 1; i <= 4; i++) cyc(1, 32'(i), 0);
      sum = 0;
      for (int i = 0; i < 4; i++) begin
         cyc(0, 0, 1);
         cyc(0, 0, 0);
         chk("handshake out_data", bus.out_data, 32'(i + 1));
         sum += int'(bus.out_data);
      end
      chk("handshake sum", 32'(sum), 10);
      chk("handshake read_ready", 32'(bus.read_ready), 0);

      // Simultaneous push and pop at count 2, across pointer wraps.
      cyc(1, 200, 0);
      cyc(1, 201, 0);
      for (int i = 0; i < 10; i++) begin
         cyc(1, 32'(100 + i), 1);
         chk("stream count", 32'(bus.count), 2);
         chk("stream out_data", bus.out_data, (i < 2) ? 32'(200 + i) : 32'(100 + i - 2));
      end
      cyc(0, 0, 1);
      chk("stream tail0", bus.out_data, 108);
      cyc(0, 0, 1);
      chk("stream tail1", bus.out_data, 109);

      // Pop at empty with a simultaneous push: no bypass.
      cyc(1, 32'hAB, 1);
      chk("empty pop out_data", bus.out_data, 109);
      chk("empty pop count", 32'(bus.count), 1);

      // Push at full with a simultaneous pop: the push is dropped.
      cyc(1, 32'h10, 0);
      cyc(1, 32'h11, 0);
      cyc(1, 32'h12, 0);
      chk("refill count", 32'(bus.count), 4);
      cyc(1, 32'hEE, 1);
      chk("full pop out_data", bus.out_data, 32'hAB);
      chk("full pop count", 32'(bus.count), 3);
      for (int i = 0; i < 3; i++) begin
         cyc(0, 0, 1);
         chk("after full out_data", bus.out_data, 32'(32'h10 + i));
      end
      chk("after full read_ready", 32'(bus.read_ready), 0);

      // Reset mid-operation wins over a simultaneous push and pop.
      cyc(1, 1, 0);
      cyc(1, 2, 0);
      cyc(1, 3, 0);
      chk("pre-reset count", 32'(bus.count), 3);
      rst = 1'b1;
      cyc(1, 4, 1);
      rst = 1'b0;
      chk("reset count", 32'(bus.count), 0);
      chk("reset read_ready", 32'(bus.read_ready), 0);
      chk("reset out_data", bus.out_data, 0);
      cyc(1, 32'h55, 0);
      cyc(0, 0, 1);
      chk("post-reset out_data", bus.out_data, 32'h55);
      cyc(0, 0, 0);
      cyc(0, 0, 0);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end
endmodule

// File: doc/channel_fifo_src.md
CHANNEL_FIFO_SRC -- requirements
Module: channel_fifo_src

Interface
REQ-001 Parameters SHALL be, one per line: name, default, meaning.
- WIDTH, 32, data word width in bits.
- DEPTH, 4, entry count; SHALL be a power of two, at least 2.

REQ-002 Ports SHALL be, one per line: name, direction, width, meaning.
- clk, input, 1, clock; all state updates on its rising edge.
- rst, input, 1, reset; synchronous, active-high.
- in_data, input, WIDTH, producer write word.
- write_valid, input, 1, producer push request.
- write_ready, output, 1, space available (not full).
- read_valid, input, 1, consumer pop request.
- read_ready, output, 1, data available (not empty).
- out_data, output, WIDTH, registered last-popped word.
- count, output, $clog2(DEPTH+1), current occupancy.

Function
REQ-003 Storage SHALL be a circular buffer: DEPTH words, write pointer wp, read pointer rp, occupancy counter cnt.
- Pointer width SHALL be $clog2(DEPTH).
- Pointers SHALL wrap modulo DEPTH.

REQ-004 Flag outputs SHALL be decoded combinationally from cnt.
- write_ready = (cnt != DEPTH).
- read_ready = (cnt != 0).
- count = cnt.

REQ-005 Push SHALL occur on a clock edge where write_valid=1 and write_ready=1.
- mem[wp] <= in_data.
- wp <= wp+1.

REQ-006 Pop SHALL occur on a clock edge where read_valid=1 and read_ready=1.
- out_data <= mem[rp].
- rp <= rp+1.

REQ-007 out_data SHALL hold its value on every edge without a pop. The popped word is therefore visible the cycle after read_valid is asserted and remains stable until the next pop.

REQ-008 Pop latency SHALL be 1 cycle: read_valid asserted in cycle N gives the word on out_data in cycle N+1.

REQ-009 Push-to-read_ready latency SHALL be 1 cycle: a push into an empty buffer at edge N raises read_ready after edge N.

REQ-010 Occupancy update SHALL be:
- cnt+1 on push only.
- cnt-1 on pop only.
- unchanged on simultaneous push and pop.
- unchanged when neither occurs.

REQ-011 Full boundary: write_valid with cnt=DEPTH SHALL be ignored, including when a pop occurs in the same cycle. No overwrite; wp and mem are unchanged. Only the pop takes effect.

REQ-012 Empty boundary: read_valid with cnt=0 SHALL be ignored, including when a push occurs in the same cycle. No bypass; out_data and rp are unchanged. Only the push takes effect.

REQ-013 Ordering SHALL be strict FIFO order across any number of pointer wrap-arounds.

REQ-014 Data integrity: in_data SHALL be sampled only at a push edge. The value of in_data at other times has no effect.

REQ-015 The block SHALL never stall a port combinationally on the opposite port's request. write_ready SHALL NOT depend on read_valid, and read_ready SHALL NOT depend on write_valid.

Reset
REQ-016 While rst=1 at a clock edge, state SHALL clear: wp=0, rp=0, cnt=0, out_data=0.

REQ-017 After reset, outputs SHALL be: write_ready=1, read_ready=0, count=0, out_data=0.

REQ-018 Memory contents SHALL NOT be reset and SHALL NOT be observable before they are written.

REQ-019 rst SHALL take priority over simultaneous push and pop. Reset mid-operation SHALL discard all stored words. The first push after reset SHALL land at index 0.

Verification
REQ-020 A bench SHALL cover these directed scenarios.
- Reset then idle: all outputs stay at their REQ-017 values for 10 cycles.
- Push 5, 6, 7, 8 on consecutive cycles, DEPTH=4 -> count 4, write_ready=0.
  - A fifth push of 9 is ignored.
  - Pops then return 5, 6, 7, 8 on out_data, each one cycle after its read_valid.
- Consumer handshake (pulse read_valid one cycle, sample out_data two cycles later) draining four pushed words 1, 2, 3, 4 -> out_data sequence 1, 2, 3, 4; final sum 10; read_ready=0 after the fourth pop.
- Simultaneous push and pop at count 2 for 10 cycles with in_data 100..109 -> count stays 2; out_data follows in order, including pointer wraps.
- Edge conditions:
  - Pop at empty with simultaneous push of 0xAB -> out_data unchanged, count 1.
  - Push at full with simultaneous pop -> count 3, the pushed word is dropped.
- rst asserted at count 3 -> count 0, read_ready 0, out_data 0.
  - Next push of 0x55 followed by a pop -> out_data 0x55.
